wb_port_arbiter: RTL and testbench

// - Shares the single register-file write port between the pipeline writeback stage and a

---
 rtl/wb_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-unit results queue
// in a small FIFO with a starvation stall. Optional same-cycle bypass via WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pipe_valid,
  input  logic                     pipe_wen,
  input  logic [4:0]               pipe_rd,
  input  logic [XLEN-1:0]          pipe_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [XLEN-1:0]          lu_data,
  output logic                     rf_wen,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     stall_pipe,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} state_t;

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]   starve_reg, starve_inc;
  state_t          state_reg;
  logic            stall_reg;

  logic pipe_act, empty, full, push, pop, bypass;
  logic [31:0] entry_hot [DEPTH];
  logic [31:0] mask_all;

  assign pipe_act = pipe_valid & pipe_wen & (pipe_rd != 5'd0);
  assign empty    = (cnt_reg == '0);
  assign full     = (cnt_reg == CW'(DEPTH));

`ifdef WB_ARB_BYPASS_EN
  assign bypass = empty & ~pipe_act & lu_valid & (lu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // rd = 0 results are accepted by the handshake but never enter the FIFO
  assign push = ~reset & lu_valid & ~full & (lu_rd != 5'd0) & ~bypass;
  assign pop  = ~reset & ~pipe_act & ~empty;

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = '0;
    if (!reset) begin
      if (pipe_act) begin
        rf_wen   = 1'b1;
        rf_rd    = pipe_rd;
        rf_wdata = pipe_data;
      end else if (!empty) begin
        rf_wen   = 1'b1;
        rf_rd    = rd_mem[rd_ptr_reg];
        rf_wdata = data_mem[rd_ptr_reg];
      end else if (bypass) begin
        rf_wen   = 1'b1;
        rf_rd    = lu_rd;
        rf_wdata = lu_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= lu_rd;
      data_mem[wr_ptr_reg] <= lu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      valid_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (push) begin
        wr_ptr_reg            <= wr_ptr_reg + AW'(1);
        valid_reg[wr_ptr_reg] <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg            <= rd_ptr_reg + AW'(1);
        valid_reg[rd_ptr_reg] <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hot
      assign entry_hot[gi] = valid_reg[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    mask_all = 32'd0;
    for (int i = 0; i < DEPTH; i++) mask_all = mask_all | entry_hot[i];
  end

  assign starve_inc = starve_reg + SW'(1);

  // Starvation FSM: counts cycles the head is denied, then forces a bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          starve_reg <= '0;
          stall_reg  <= 1'b0;
          if (push) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pop) begin
            starve_reg <= '0;
            state_reg  <= (cnt_next == '0) ? ST_IDLE : ST_WAIT;
          end else begin
            starve_reg <= starve_inc;
            if (starve_inc == SW'(STARVE_LIMIT)) begin
              state_reg <= ST_STALL;
              stall_reg <= 1'b1;
            end
          end
        end
        ST_STALL: begin
          if (pop) begin
            starve_reg <= '0;
            stall_reg  <= 1'b0;
            state_reg  <= (cnt_next == '0) ? ST_IDLE : ST_WAIT;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          starve_reg <= '0;
          stall_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign lu_ready   = ~reset & ~full;
  assign stall_pipe = ~reset & stall_reg;
  assign busy_mask  = reset ? 32'd0 : (mask_all & ~32'd1);
  assign fifo_cnt   = reset ? '0 : cnt_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, starvation/drain/reset sequences,
// and a scoreboard of queued long-unit results.
module tb_wb_port_arbiter;

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock, reset;
  logic        pipe_valid, pipe_wen, lu_valid, lu_ready, rf_wen, stall_pipe;
  logic [4:0]  pipe_rd, lu_rd, rf_rd;
  logic [31:0] pipe_data, lu_data, rf_wdata, busy_mask;
  logic [2:0]  fifo_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic pv; logic pw; logic [4:0] prd; logic [31:0] pd;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic ew; logic [4:0] erd; logic [31:0] ed;
    logic [2:0] ecnt; logic [31:0] ebusy; logic erdy;
  } vec_t;

  typedef struct { logic [4:0] rd; logic [31:0] d; } wr_t;

  vec_t tbl [12];
  wr_t  sb [$];

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe), .busy_mask(busy_mask), .fifo_cnt(fifo_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic pv, input logic pw, input logic [4:0] prd,
                              input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ld, input logic ew, input logic [4:0] erd,
                              input logic [31:0] ed, input logic [2:0] ecnt,
                              input logic [31:0] ebusy, input logic erdy);
    vec_t v;
    v.pv = pv; v.pw = pw; v.prd = prd; v.pd = pd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.ew = ew; v.erd = erd; v.ed = ed;
    v.ecnt = ecnt; v.ebusy = ebusy; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic pw, input logic [4:0] prd,
                       input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ld);
    pipe_valid = pv; pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic starve_seq(input int extra);
    drive(1'b1, 1'b1, 5'd3, 32'h3000, 1'b1, 5'd7, 32'h77);
    @(negedge clock);
    chk("starve_push_rd", {27'd0, rf_rd}, 32'd3);
    chk("starve_push_stall", {31'd0, stall_pipe}, 32'd0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 5'd3, 32'h3000 + k, 1'b0, 5'd0, 32'd0);
      @(negedge clock);
      chk($sformatf("starve_wait%0d_stall", k), {31'd0, stall_pipe}, 32'd0);
      chk($sformatf("starve_wait%0d_cnt", k), {29'd0, fifo_cnt}, 32'd1);
      tick();
    end
    for (int e = 0; e < extra; e++) begin
      drive(1'b1, 1'b1, 5'd3, 32'h3100, 1'b0, 5'd0, 32'd0);
      @(negedge clock);
      chk($sformatf("stall_hold%0d", e), {31'd0, stall_pipe}, 32'd1);
      chk($sformatf("stall_hold%0d_rd", e), {27'd0, rf_rd}, 32'd3);
      tick();
    end
    idle();
    @(negedge clock);
    chk("stall_high", {31'd0, stall_pipe}, 32'd1);
    chk("stall_drain_wen", {31'd0, rf_wen}, 32'd1);
    chk("stall_drain_rd", {27'd0, rf_rd}, 32'd7);
    chk("stall_drain_data", rf_wdata, 32'h77);
    tick();
    @(negedge clock);
    chk("stall_fall", {31'd0, stall_pipe}, 32'd0);
    chk("stall_after_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("stall_after_wen", {31'd0, rf_wen}, 32'd0);
    tick();
  endtask

  initial begin
    wr_t w;
    // rows run back to back; FIFO state carries from one row to the next
    tbl[0]  = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    3'd0, 32'h0, 1);
    tbl[1]  = mk(0, 0, 5'd0, 32'h0,    1, 5'd5, 32'h1234, BYP, BYP ? 5'd5 : 5'd0,
                 BYP ? 32'h1234 : 32'h0, 3'd0, 32'h0, 1);
    tbl[2]  = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    !BYP, 5'd5, 32'h1234,
                 BYP ? 3'd0 : 3'd1, BYP ? 32'h0 : 32'h20, 1);
    tbl[3]  = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    3'd0, 32'h0, 1);
    tbl[4]  = mk(1, 1, 5'd0, 32'h66,   1, 5'd0, 32'h55,   0, 5'd0, 32'h0,    3'd0, 32'h0, 1);
    tbl[5]  = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    3'd0, 32'h0, 1);
    tbl[6]  = mk(1, 0, 5'd3, 32'hAAAA, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    3'd0, 32'h0, 1);
    tbl[7]  = mk(1, 1, 5'd3, 32'hAAAA, 1, 5'd7, 32'h77,   1, 5'd3, 32'hAAAA, 3'd0, 32'h0, 1);
    tbl[8]  = mk(1, 1, 5'd3, 32'hBBBB, 0, 5'd0, 32'h0,    1, 5'd3, 32'hBBBB, 3'd1, 32'h80, 1);
    tbl[9]  = mk(0, 0, 5'd0, 32'h0,    1, 5'd8, 32'h88,   1, 5'd7, 32'h77,   3'd1, 32'h80, 1);
    tbl[10] = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd8, 32'h88,   3'd1, 32'h100, 1);
    tbl[11] = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    3'd0, 32'h0, 1);

    reset = 1'b1;
    idle();
    tick();
    tick();
    @(negedge clock);
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall_pipe}, 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].pv, tbl[i].pw, tbl[i].prd, tbl[i].pd, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      @(negedge clock);
      chk($sformatf("row%0d_wen", i), {31'd0, rf_wen}, {31'd0, tbl[i].ew});
      if (tbl[i].ew) begin
        chk($sformatf("row%0d_rd", i), {27'd0, rf_rd}, {27'd0, tbl[i].erd});
        chk($sformatf("row%0d_data", i), rf_wdata, tbl[i].ed);
      end
      chk($sformatf("row%0d_cnt", i), {29'd0, fifo_cnt}, {29'd0, tbl[i].ecnt});
      chk($sformatf("row%0d_busy", i), busy_mask, tbl[i].ebusy);
      chk($sformatf("row%0d_ready", i), {31'd0, lu_ready}, {31'd0, tbl[i].erdy});
      chk($sformatf("row%0d_stall", i), {31'd0, stall_pipe}, 32'd0);
      $display("row %0d: wen=%0d rd=%0d data=%h cnt=%0d", i, rf_wen, rf_rd, rf_wdata, fifo_cnt);
      tick();
    end

    starve_seq(0);
    starve_seq(2);

    // fill to full behind a busy pipeline, then drain in push order
    for (int i = 0; i < 4; i++) begin
      w.rd = 5'(10 + i);
      w.d  = $urandom;
      drive(1'b1, 1'b1, 5'd3, 32'h100 + i, 1'b1, w.rd, w.d);
      @(negedge clock);
      chk($sformatf("fill%0d_ready", i), {31'd0, lu_ready}, 32'd1);
      chk($sformatf("fill%0d_rd", i), {27'd0, rf_rd}, 32'd3);
      sb.push_back(w);
      tick();
    end
    drive(1'b1, 1'b1, 5'd3, 32'h200, 1'b1, 5'd14, 32'hDEAD);
    @(negedge clock);
    chk("full_cnt", {29'd0, fifo_cnt}, 32'd4);
    chk("full_ready", {31'd0, lu_ready}, 32'd0);
    chk("full_busy", busy_mask, 32'h3C00);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hDEAD);
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      @(negedge clock);
      w = sb.pop_front();
      chk($sformatf("drain%0d_cnt", c), {29'd0, fifo_cnt}, 32'(sb.size() + 1));
      chk($sformatf("drain%0d_wen", c), {31'd0, rf_wen}, 32'd1);
      chk($sformatf("drain%0d_rd", c), {27'd0, rf_rd}, {27'd0, w.rd});
      chk($sformatf("drain%0d_data", c), rf_wdata, w.d);
      $display("drain %0d: rd=%0d data=%h", c, rf_rd, rf_wdata);
      tick();
      idle();
    end
    chk("drain_empty_sb", 32'(sb.size()), 32'd0);
    @(negedge clock);
    chk("drain_done_wen", {31'd0, rf_wen}, 32'd0);
    chk("drain_done_cnt", {29'd0, fifo_cnt}, 32'd0);
    tick();

    // reset with three queued results discards them
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd3, 32'h300, 1'b1, 5'(20 + i), 32'h400 + i);
      tick();
    end
    drive(1'b1, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    chk("prerst_cnt", {29'd0, fifo_cnt}, 32'd3);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 32'h300, 1'b1, 5'd23, 32'h999);
    @(negedge clock);
    chk("midrst_wen", {31'd0, rf_wen}, 32'd0);
    chk("midrst_ready", {31'd0, lu_ready}, 32'd0);
    chk("midrst_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("midrst_busy", busy_mask, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clock);
    chk("postrst_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("postrst_busy", busy_mask, 32'd0);
    chk("postrst_stall", {31'd0, stall_pipe}, 32'd0);
    chk("postrst_wen", {31'd0, rf_wen}, 32'd0);
    tick();

`ifdef WB_ARB_BYPASS_EN
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hBEEF);
    @(negedge clock);
    chk("byp_wen", {31'd0, rf_wen}, 32'd1);
    chk("byp_rd", {27'd0, rf_rd}, 32'd9);
    chk("byp_data", rf_wdata, 32'hBEEF);
    chk("byp_busy", busy_mask, 32'd0);
    tick();
    idle();
    @(negedge clock);
    chk("byp_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("byp_after_wen", {31'd0, rf_wen}, 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
